cordic_iter_ctrl: RTL
=====================

CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 SHALL have parameter N_FRAC, default 15, giving fraction bits; every data word is signed N_FRAC+1 bits (Q1.N_FRAC).
REQ-002 SHALL have parameter BW_SHIFT_VALUE, default 4, giving the shift-amount width.
REQ-003 SHALL have parameter N_ITER, default 14, giving micro-rotations per operation; legal range 1..15.
REQ-004 SHALL have parameter X_INIT, default 19894, giving the gain-compensated initial x (≈0.6071).
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  reset; asynchronous assertion, active-low.
REQ-007 angle_i  input  N_FRAC+1  target angle in radians (Q1.N_FRAC), legal range [-1.0, 1.0).
REQ-008 valid_i  input  1  angle_i is valid.
REQ-009 ready_o  output  1  block can accept a new angle.
REQ-010 cos_o  output  N_FRAC+1  registered cosine result.
REQ-011 sin_o  output  N_FRAC+1  registered sine result.
REQ-012 valid_o  output  1  cos_o/sin_o hold a result.
REQ-013 ready_i  input  1  downstream consumes the result.
REQ-014 busy_o  output  1  high when the state is not IDLE.

Function
REQ-015 SHALL implement the FSM IDLE -> ROTATE -> DONE -> IDLE.
REQ-016 IDLE: ready_o=1; when valid_i=1, SHALL load x=X_INIT, y=0, z=angle_i, iteration counter i=0, and go to ROTATE.
REQ-017 ROTATE: ready_o=0; each cycle SHALL perform one micro-rotation with shift i and LUT angle atan(2^-i), then increment i.
REQ-018 Micro-rotation when z<0: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+atan_i.
REQ-019 Micro-rotation when z>=0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-atan_i.
REQ-020 Shifts SHALL be arithmetic; adds SHALL wrap at N_FRAC+1 bits with no saturation.
REQ-021 atan LUT (N_FRAC=15), index 0..14: 25736, 15193, 8027, 4075, 2045, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
REQ-022 After the micro-rotation with i=N_ITER-1, SHALL copy x to cos_o and y to sin_o, set valid_o=1, and go to DONE.
REQ-023 Latency SHALL be exactly N_ITER+1 cycles from the accepting edge to the first cycle valid_o=1 (15 cycles at default).
REQ-024 DONE: valid_o=1; cos_o/sin_o stable; ready_o=0; SHALL remain in DONE while ready_i=0.
REQ-025 DONE with ready_i=1: result consumed on that edge; SHALL clear valid_o and return to IDLE; no new accept on the same edge.
REQ-026 valid_i while in ROTATE or DONE SHALL be ignored; the angle is neither queued nor able to corrupt state.
REQ-027 cos_o/sin_o SHALL change only on the REQ-022 transition and hold their value in IDLE.
REQ-028 Sustained throughput SHALL be one result per N_ITER+2 cycles with valid_i=1 and ready_i=1.

Reset
REQ-029 rst_i=0 SHALL immediately force: state IDLE, i=0, x=y=z=0, cos_o=0, sin_o=0, valid_o=0, busy_o=0, ready_o=1.
REQ-030 Reset mid-ROTATE or mid-DONE SHALL abandon the operation; no valid_o pulse SHALL follow the release of rst_i.
REQ-031 After rst_i rises, the first accept SHALL be possible on the next rising edge.

Verification
REQ-032 angle_i=0 -> valid_o 15 cycles later; cos_o=32763±8, sin_o=0±8.
REQ-033 angle_i=17157 (π/6) -> cos_o=28378±8, sin_o=16384±8; angle_i=-17157 -> cos_o=28378±8, sin_o=-16384±8.
REQ-034 Backpressure: ready_i=0 for 20 cycles after valid_o -> valid_o, cos_o and sin_o stable throughout; clear one cycle after ready_i=1.
REQ-035 valid_i pulsed with angle 5000 during ROTATE -> ignored; the result matches the original angle and exactly one valid_o episode occurs.
REQ-036 rst_i=0 at iteration 7 -> outputs zero immediately, no valid_o afterwards; a new angle 25736 (π/4) gives cos_o≈sin_o≈23170±8.
REQ-037 Back-to-back: 3 angles with ready_i=1 -> valid_o pulses spaced 16 cycles apart.

Source files
------------

// File: rtl/cordic_iter_ctrl_if.sv
// Handshake bundle for the iterative CORDIC sine/cosine engine: angle in,
// cos/sin result out, with valid/ready flow control on both sides.
interface cordic_iter_ctrl_if #(
  parameter int N_FRAC = 15
);
  localparam int W = N_FRAC + 1;

  logic signed [W-1:0] angle_i;
  logic                valid_i;
  logic                ready_o;
  logic signed [W-1:0] cos_o;
  logic signed [W-1:0] sin_o;
  logic                valid_o;
  logic                ready_i;
  logic                busy_o;

  modport master (
    output angle_i, valid_i, ready_i,
    input  ready_o, cos_o, sin_o, valid_o, busy_o
  );

  modport slave (
    input  angle_i, valid_i, ready_i,
    output ready_o, cos_o, sin_o, valid_o, busy_o
  );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, N_ITER steps,
// result held until the downstream side takes it.
module cordic_iter_ctrl #(
  parameter int N_FRAC         = 15,
  parameter int BW_SHIFT_VALUE = 4,
  parameter int N_ITER         = 14,
  parameter int X_INIT         = 19894
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cordic_iter_ctrl_if.slave bus
);
  localparam int W = N_FRAC + 1;

  typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic signed [W-1:0]       x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [W-1:0]       cos_q, cos_d, sin_q, sin_d;
  logic [BW_SHIFT_VALUE-1:0] i_q, i_d;

  logic signed [W-1:0]       rot_x, rot_y, rot_z, atan_i;

  // atan(2^-i) table in Q1.15, rescaled to the configured fraction width.
  function automatic logic signed [W-1:0] atan_lut(input logic [BW_SHIFT_VALUE-1:0] idx);
    int base;
    int scaled;
    case (int'(idx))
      0:       base = 25736;
      1:       base = 15193;
      2:       base = 8027;
      3:       base = 4075;
      4:       base = 2045;
      5:       base = 1024;
      6:       base = 512;
      7:       base = 256;
      8:       base = 128;
      9:       base = 64;
      10:      base = 32;
      11:      base = 16;
      12:      base = 8;
      13:      base = 4;
      14:      base = 2;
      default: base = 0;
    endcase
    if (N_FRAC >= 15) scaled = base <<< (N_FRAC - 15);
    else              scaled = base >>> (15 - N_FRAC);
    return scaled[W-1:0];
  endfunction

  // One micro-rotation; the sign of the residual angle picks the direction.
  always_comb begin
    atan_i = atan_lut(i_q);
    if (z_q[W-1]) begin
      rot_x = x_q + (y_q >>> i_q);
      rot_y = y_q - (x_q >>> i_q);
      rot_z = z_q + atan_i;
    end else begin
      rot_x = x_q - (y_q >>> i_q);
      rot_y = y_q + (x_q >>> i_q);
      rot_z = z_q - atan_i;
    end
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      S_IDLE: begin
        if (bus.valid_i) begin
          x_d     = W'(X_INIT);
          y_d     = '0;
          z_d     = bus.angle_i;
          i_d     = '0;
          state_d = S_ROTATE;
        end
      end
      S_ROTATE: begin
        x_d = rot_x;
        y_d = rot_y;
        z_d = rot_z;
        i_d = i_q + BW_SHIFT_VALUE'(1);
        if (i_q == BW_SHIFT_VALUE'(N_ITER - 1)) begin
          cos_d   = rot_x;
          sin_d   = rot_y;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.valid_o = (state_q == S_DONE);
  assign bus.cos_o   = cos_q;
  assign bus.sin_o   = sin_q;
endmodule
